// File: rtl/md_pkg.sv
// Shared M-extension types and constants for the divide issue path and its helpers.
package md_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;

    localparam int CNT_W = 4;

endpackage

// File: rtl/md_special_case.sv
// Flags divide/remainder ops whose result follows from the operands alone (x/0, INT_MIN/-1).
// Latency: combinational; backpressure: none, pure function of its inputs.
module md_special_case
    import md_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic        is_special_o,
    output logic [31:0] special_result_o
);

    div_op_e op;
    logic    div_zero;
    logic    overflow;

    assign op       = div_op_e'(op_i);
    assign div_zero = (op2_i == '0);
    assign overflow = ((op == DIV) || (op == REM)) && (op1_i == INT_MIN) && (op2_i == NEG_ONE);

    always_comb begin
        is_special_o     = div_zero || overflow;
        special_result_o = '0;
        if (div_zero) begin
            special_result_o = ((op == DIV) || (op == DIVU)) ? DIV0_QUOT : op1_i;
        end else if (overflow) begin
            special_result_o = (op == DIV) ? INT_MIN : '0;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Holds divider operands for DIV_CYCLES cycles and stalls EX; x/0, overflow and cache hits finish in one cycle.
// Latency: 1 + DIV_CYCLES stall cycles (1 for special/hit), result next cycle; backpressure: drives stall_o, no downstream ready.
module div_issue_ctrl
    import md_pkg::*;
#(
    parameter int DIV_CYCLES   = 4,
    parameter bit ENABLE_CACHE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  div_opcode_i,
    input  logic [31:0] operand1_i,
    input  logic [31:0] operand2_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [1:0]  div_opcode_o,
    output logic [31:0] operand1_o,
    output logic [31:0] operand2_o,
    input  logic [31:0] result_divide_i,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_o
);

    localparam logic [CNT_W-1:0] CNT_INIT = 4'(DIV_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         opc_q, opc_d;
    logic [31:0]        op1_q, op1_d;
    logic [31:0]        op2_q, op2_d;
    logic [4:0]         rd_q, rd_d;
    logic [31:0]        res_q, res_d;
    logic [4:0]         rd_out_q, rd_out_d;
    logic               cache_vld_q, cache_vld_d;
    logic [1:0]         cache_op_q, cache_op_d;
    logic [31:0]        cache_a_q, cache_a_d;
    logic [31:0]        cache_b_q, cache_b_d;
    logic [31:0]        cache_res_q, cache_res_d;

    logic               accept;
    logic               cache_hit;
    logic               hold_done;
    logic               is_special;
    logic [31:0]        special_result;

    md_special_case u_special (
        .op_i             (div_opcode_i),
        .op1_i            (operand1_i),
        .op2_i            (operand2_i),
        .is_special_o     (is_special),
        .special_result_o (special_result)
    );

    assign accept    = (state_q == IDLE) && start_i && !flush_i;
    assign cache_hit = ENABLE_CACHE && cache_vld_q && (cache_op_q == div_opcode_i)
                       && (cache_a_q == operand1_i) && (cache_b_q == operand2_i);
    assign hold_done = (state_q == HOLD) && (cnt_q == '0) && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opc_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            rd_q        <= '0;
            res_q       <= '0;
            rd_out_q    <= '0;
            cache_vld_q <= 1'b0;
            cache_op_q  <= '0;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_res_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opc_q       <= opc_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rd_q        <= rd_d;
            res_q       <= res_d;
            rd_out_q    <= rd_out_d;
            cache_vld_q <= cache_vld_d;
            cache_op_q  <= cache_op_d;
            cache_a_q   <= cache_a_d;
            cache_b_q   <= cache_b_d;
            cache_res_q <= cache_res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (is_special || cache_hit) ? DONE : HOLD;
            HOLD: begin
                if (flush_i)            state_d = IDLE;
                else if (cnt_q == '0)   state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Special results take priority over the cache and never write it.
    always_comb begin
        cnt_d       = cnt_q;
        opc_d       = opc_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        rd_d        = rd_q;
        res_d       = res_q;
        rd_out_d    = rd_out_q;
        cache_vld_d = cache_vld_q;
        cache_op_d  = cache_op_q;
        cache_a_d   = cache_a_q;
        cache_b_d   = cache_b_q;
        cache_res_d = cache_res_q;
        if (accept) begin
            opc_d = div_opcode_i;
            op1_d = operand1_i;
            op2_d = operand2_i;
            rd_d  = rd_i;
            if (is_special) begin
                res_d    = special_result;
                rd_out_d = rd_i;
            end else if (cache_hit) begin
                res_d    = cache_res_q;
                rd_out_d = rd_i;
            end else begin
                cnt_d = CNT_INIT;
            end
        end
        if (state_q == HOLD) begin
            cnt_d = (flush_i || (cnt_q == '0)) ? '0 : cnt_q - 4'd1;
        end
        if (hold_done) begin
            res_d       = result_divide_i;
            rd_out_d    = rd_q;
            cache_vld_d = 1'b1;
            cache_op_d  = opc_q;
            cache_a_d   = op1_q;
            cache_b_d   = op2_q;
            cache_res_d = result_divide_i;
        end
    end

    always_comb begin
        stall_o = accept || (state_q == HOLD);
        busy_o  = (state_q != IDLE);
        valid_o = (state_q == DONE) && !flush_i;
    end

    assign div_opcode_o = opc_q;
    assign operand1_o   = op1_q;
    assign operand2_o   = op2_q;
    assign result_o     = res_q;
    assign rd_o         = rd_out_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed vector table, corner sequences, then random ops vs a reference model.
module tb_div_issue_ctrl;

    localparam int DC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_i, start_nc, flush_i;
    logic [1:0]  div_opcode_i;
    logic [31:0] operand1_i, operand2_i;
    logic [4:0]  rd_i;

    logic        stall_o, busy_o, valid_o;
    logic [1:0]  div_opcode_o;
    logic [31:0] operand1_o, operand2_o, result_o, res_div;
    logic [4:0]  rd_o;

    logic        stall_nc, busy_nc, valid_nc;
    logic [1:0]  opc_nc;
    logic [31:0] op1_nc, op2_nc, result_nc, res_div_nc;
    logic [4:0]  rd_nc;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   q = sa / sb;
            2'b01:   q = ua / ub;
            2'b10:   q = sa % sb;
            default: q = ua % ub;
        endcase
        return q[31:0];
    endfunction

    always_comb res_div    = ref_div(div_opcode_o, operand1_o, operand2_o);
    always_comb res_div_nc = ref_div(opc_nc, op1_nc, op2_nc);

    div_issue_ctrl #(.DIV_CYCLES(DC), .ENABLE_CACHE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .div_opcode_i(div_opcode_i),
        .operand1_i(operand1_i), .operand2_i(operand2_i), .rd_i(rd_i), .flush_i(flush_i),
        .stall_o(stall_o), .busy_o(busy_o), .div_opcode_o(div_opcode_o),
        .operand1_o(operand1_o), .operand2_o(operand2_o), .result_divide_i(res_div),
        .valid_o(valid_o), .result_o(result_o), .rd_o(rd_o)
    );

    div_issue_ctrl #(.DIV_CYCLES(DC), .ENABLE_CACHE(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .start_i(start_nc), .div_opcode_i(div_opcode_i),
        .operand1_i(operand1_i), .operand2_i(operand2_i), .rd_i(rd_i), .flush_i(flush_i),
        .stall_o(stall_nc), .busy_o(busy_nc), .div_opcode_o(opc_nc),
        .operand1_o(op1_nc), .operand2_o(op2_nc), .result_divide_i(res_div_nc),
        .valid_o(valid_nc), .result_o(result_nc), .rd_o(rd_nc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input bit sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int flush_at,
                          output int stalls, output bit vld, output logic [31:0] res,
                          output logic [4:0] rdo, output bit post_vld, output bit hold_bad);
        stalls = 0; vld = 1'b0; res = '0; rdo = '0; post_vld = 1'b0; hold_bad = 1'b0;
        for (int c = 0; c < 10 && !vld; c++) begin
            @(posedge clk); #1;
            start_i  = (c == 0) && !sel;
            start_nc = (c == 0) && sel;
            flush_i  = (c == flush_at);
            if (c == 0) begin
                div_opcode_i = op; operand1_i = a; operand2_i = b; rd_i = rd;
            end else begin
                div_opcode_i = 2'($urandom); operand1_i = $urandom; operand2_i = $urandom; rd_i = 5'($urandom);
            end
            @(negedge clk);
            if (sel ? stall_nc : stall_o) stalls++;
            if (sel ? busy_nc : busy_o) begin
                if ((sel ? opc_nc : div_opcode_o) != op || (sel ? op1_nc : operand1_o) != a
                    || (sel ? op2_nc : operand2_o) != b) hold_bad = 1'b1;
            end
            if (sel ? valid_nc : valid_o) begin
                vld = 1'b1;
                res = sel ? result_nc : result_o;
                rdo = sel ? rd_nc : rd_o;
            end
        end
        @(posedge clk); #1;
        start_i = 1'b0; start_nc = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        post_vld = sel ? valid_nc : valid_o;
    endtask

    task automatic check_op(input string name, input bit sel, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input int flush_at,
                            input bit exp_vld, input int exp_stalls, input logic [31:0] exp_res);
        int          st;
        bit          v, pv, hb;
        logic [31:0] r;
        logic [4:0]  ro;
        run_op(sel, op, a, b, rd, flush_at, st, v, r, ro, pv, hb);
        chk($sformatf("%s stalls", name), 32'(st), 32'(exp_stalls));
        chk($sformatf("%s valid", name), 32'(v), 32'(exp_vld));
        if (exp_vld) begin
            chk($sformatf("%s result", name), r, exp_res);
            chk($sformatf("%s rd", name), 32'(ro), 32'(rd));
        end
        chk($sformatf("%s valid_after", name), 32'(pv), 32'd0);
        chk($sformatf("%s operands_stable", name), 32'(hb), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; start_i = 1'b0; start_nc = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          stalls;
        logic [31:0] res;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bit          mc_vld, special, hit, ev;
        logic [1:0]  mc_op;
        logic [31:0] mc_a, mc_b;
        int          fa, lat, es;
        bit          seen_v;

        tbl[0]  = '{2'b01, 32'd100,        32'd7,          5'd1,  5, 32'h0000_000E};
        tbl[1]  = '{2'b00, 32'd5,          32'd0,          5'd2,  1, 32'hFFFF_FFFF};
        tbl[2]  = '{2'b11, 32'd5,          32'd0,          5'd3,  1, 32'h0000_0005};
        tbl[3]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd4,  1, 32'h8000_0000};
        tbl[4]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd5,  1, 32'h0000_0000};
        tbl[5]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd6,  5, 32'hFFFF_FFFF};
        tbl[6]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd7,  1, 32'hFFFF_FFFF};
        tbl[7]  = '{2'b01, 32'd100,        32'd7,          5'd8,  5, 32'h0000_000E};
        tbl[8]  = '{2'b00, 32'hFFFF_FFEC,  32'd3,          5'd9,  5, 32'hFFFF_FFFA};
        tbl[9]  = '{2'b11, 32'd0,          32'd0,          5'd10, 1, 32'h0000_0000};
        tbl[10] = '{2'b00, 32'hFFFF_FFEC,  32'd3,          5'd11, 1, 32'hFFFF_FFFA};
        tbl[11] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31, 5, 32'h0000_0001};
        tbl[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 5, 32'h0000_0000};
        tbl[13] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 5, 32'h8000_0000};

        rst_n = 1'b1; start_i = 1'b0; start_nc = 1'b0; flush_i = 1'b0;
        div_opcode_i = '0; operand1_i = '0; operand2_i = '0; rd_i = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset stall", 32'(stall_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset valid", 32'(valid_o), 32'd0);
        chk("reset result", result_o, 32'd0);
        chk("reset rd", 32'(rd_o), 32'd0);
        chk("reset opcode", 32'(div_opcode_o), 32'd0);
        chk("reset operand1", operand1_o, 32'd0);
        chk("reset operand2", operand2_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            check_op($sformatf("vec%0d", i), 1'b0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, -1,
                     1'b1, tbl[i].stalls, tbl[i].res);

        // Cache disabled: repeats take the full path.
        check_op("nc_rem1", 1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, -1, 1'b1, 5, 32'hFFFF_FFFF);
        check_op("nc_rem2", 1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, -1, 1'b1, 5, 32'hFFFF_FFFF);
        check_op("nc_div0", 1'b1, 2'b00, 32'd5, 32'd0, 5'd2, -1, 1'b1, 1, 32'hFFFF_FFFF);

        // Flush corners on the cached instance.
        check_op("flush_hold2", 1'b0, 2'b00, 32'd100, 32'd7, 5'd3, 2, 1'b0, 3, 32'd0);
        check_op("after_flush", 1'b0, 2'b00, 32'd100, 32'd7, 5'd3, -1, 1'b1, 5, 32'h0000_000E);
        check_op("hit_again", 1'b0, 2'b00, 32'd100, 32'd7, 5'd4, -1, 1'b1, 1, 32'h0000_000E);
        check_op("flush_hit_done", 1'b0, 2'b00, 32'd100, 32'd7, 5'd4, 1, 1'b0, 1, 32'd0);
        check_op("flush_accept", 1'b0, 2'b01, 32'd50, 32'd3, 5'd4, 0, 1'b0, 0, 32'd0);
        check_op("flush_done", 1'b0, 2'b01, 32'd9, 32'd2, 5'd5, 1 + DC, 1'b0, 1 + DC, 32'd0);
        check_op("hit_after_done_flush", 1'b0, 2'b01, 32'd9, 32'd2, 5'd5, -1, 1'b1, 1, 32'd4);

        // Reset in the middle of HOLD drops the op and the cache.
        @(posedge clk); #1;
        start_i = 1'b1; div_opcode_i = 2'b00; operand1_i = 32'd1000; operand2_i = 32'd3; rd_i = 5'd9;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        chk("midhold busy", 32'(busy_o), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midhold rst busy", 32'(busy_o), 32'd0);
        chk("midhold rst stall", 32'(stall_o), 32'd0);
        chk("midhold rst result", result_o, 32'd0);
        chk("midhold rst operand1", operand1_o, 32'd0);
        chk("midhold rst rd", 32'(rd_o), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen_v = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid_o) seen_v = 1'b1;
        end
        chk("midhold no valid", 32'(seen_v), 32'd0);
        check_op("cache_cleared", 1'b0, 2'b01, 32'd9, 32'd2, 5'd5, -1, 1'b1, 1 + DC, 32'd4);

        // Random ops against the reference model.
        do_reset();
        mc_vld = 1'b0; mc_op = '0; mc_a = '0; mc_b = '0;
        op = '0; a = '0; b = '0;
        for (int n = 0; n < 60; n++) begin
            if (n == 0 || $urandom_range(0, 2) != 0) begin
                op = 2'($urandom); a = pick(); b = pick();
            end
            fa      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            hit     = !special && mc_vld && mc_op == op && mc_a == a && mc_b == b;
            lat     = (special || hit) ? 1 : 1 + DC;
            if (fa < 0 || fa > lat) begin ev = 1'b1; es = lat; end
            else if (fa == 0)       begin ev = 1'b0; es = 0; end
            else if (fa < lat)      begin ev = 1'b0; es = fa + 1; end
            else                    begin ev = 1'b0; es = lat; end
            if (!special && !hit && (fa < 0 || fa >= lat)) begin
                mc_vld = 1'b1; mc_op = op; mc_a = a; mc_b = b;
            end
            check_op($sformatf("rnd%0d", n), 1'b0, op, a, b, 5'($urandom), fa, ev, es, ref_div(op, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
